adc2ram_mc: RTL and testbench
=============================

Name: adc2ram_mc

Overview:
Parametrised successor to the adc-FIFO-to-RAM mover. Drains NUM_CH per-channel ADC FIFOs in round-robin order into the dual-port frame RAM, starting at a console-supplied base address. Adds a per-run channel mask, a multi-frame count, address wrap, a stall timeout with fill byte, and a byte-count output for the typec sender.
Uses the console fs/fd handshake. Sits between the adc block's FIFOs and RAM port A.

Parameters:
NUM_CH, 8, number of ADC channels / FIFOs
DW, 8, FIFO and RAM data width
AW, 12, RAM address width
FW, 8, width of frame-count input
TIMEOUT, 1024, max cycles to wait on an empty FIFO before fill
FILL, 8'h00, byte written on timeout (DW wide)

Ports:
clk  in  1  single clock (ram_txc domain)
rst_n  in  1  synchronous reset, active low
fs  in  1  start request, level; held by console until fd seen
fd  out  1  done; high while fs high after run completes
ram_txa_init  in  AW  base write address, sampled at start
ch_mask  in  NUM_CH  channel enable, sampled at start; bit i = channel i
frame_num  in  FW  number of frames (one byte per enabled channel per frame), sampled at start
fifo_empty  in  NUM_CH  per-channel FIFO empty
fifo_rden  out  NUM_CH  per-channel read strobe, one-hot or zero
fifo_rxd  in  NUM_CH*DW  channel i data at [i*DW +: DW], valid cycle after rden
ram_txen  out  1  RAM write enable
ram_txa  out  AW  RAM write address
ram_txd  out  DW  RAM write data
data_len  out  AW  bytes written in the last/current run
err_timeout  out  1  sticky: at least one fill byte written this run

Behaviour:
- All outputs registered. Reset: fd=0, fifo_rden=0, ram_txen=0, ram_txa=0, ram_txd=0, data_len=0, err_timeout=0. State=IDLE. Channel index, frame counter and timeout counter = 0.
- IDLE: on fs=1, go to LOAD.
- LOAD (1 cycle): latch base, mask and frames. Clear data_len, err_timeout and the address offset. Channel index=0.
  - If mask==0 or frame_num==0, go to DONE.
  - Otherwise go to SEL.
- SEL: if mask[idx]=0, advance idx (see NEXT rules) without spending a write.
  - If fifo_empty[idx]=0, go to READ.
  - Else increment the timeout counter. At TIMEOUT, go to FILLW.
- READ (1 cycle): fifo_rden[idx]=1, then go to WRITE.
- WRITE (1 cycle): ram_txen=1, ram_txa=base+offset (mod 2^AW), ram_txd=fifo_rxd[idx].
  - Then offset+1, data_len+1, timeout counter=0, go to NEXT.
- FILLW (1 cycle): same as WRITE but ram_txd=FILL, no rden, err_timeout=1.
- NEXT: advance to the next enabled channel index above idx.
  - If none remains, frame+1 and idx restarts at the lowest enabled channel.
  - If frame reaches frame_num, go to DONE. Otherwise go to SEL.
  - Skipping disabled channels costs at most 1 cycle per channel scanned. Implementation may use a priority search in one cycle.
- Throughput: minimum 3 cycles per byte (SEL, READ, WRITE) plus NEXT. A combined NEXT/SEL is permitted if order and data are unchanged.
- DONE: fd=1 while fs=1. On fs=0, fd=0 next cycle and go to IDLE.
  - data_len and err_timeout hold until the next LOAD.
- Write order: frame-major, ascending channel index within a frame.
- Address wrap: ram_txa wraps to 0 after 2^AW-1. data_len saturates at 2^AW-1.
- fs dropping mid-run is ignored; the run completes, and fd is not asserted if fs is already low (go straight to IDLE).
- ram_txa_init, ch_mask and frame_num changing mid-run have no effect.
- rst_n=0 mid-run: next edge returns all outputs to reset values. No further rden or txen is issued.
- Exactly one rden per successful write. Never rden on an empty FIFO.

Test Plan:
- mask=8'hFF, frame_num=2, init=12'h100, all FIFOs non-empty with ch i data = 8'hi0+frame -> 16 writes at 12'h100..12'h10F, data 00,10,...,70,01,11,...,71; data_len=16; fd=1; err_timeout=0.
- mask=8'h05, frame_num=3 -> 6 writes, ch0,ch2,ch0,ch2,ch0,ch2; fifo_rden only bits 0/2; data_len=6.
- init=12'hFFE, mask=8'h03, frame_num=2 -> addresses FFE, FFF, 000, 001.
- TIMEOUT=16, ch3 held empty, mask=8'h0F, frame_num=1 -> ch3 slot written with 8'h00 about 16 cycles after SEL; err_timeout=1; no rden[3]; data_len=4.
- mask=0 -> fd=1 within 3 cycles of fs; no txen; data_len=0. Then fs=0 -> fd=0 next cycle.
- rst_n=0 after the 5th write of a 16-byte run -> all outputs 0 next edge. New fs then runs cleanly from init.

Source files
------------

// File: rtl/adc2ram_mc_if.sv
// adc2ram_mc bus: console fs/fd handshake, run setup,
// per-channel ADC FIFO read side and RAM port A write side.
interface adc2ram_mc_if #(
   parameter int NUM_CH = 8,
   parameter int DW     = 8,
   parameter int AW     = 12,
   parameter int FW     = 8
);
   logic                 fs;
   logic                 fd;
   logic [AW-1:0]        ram_txa_init;
   logic [NUM_CH-1:0]    ch_mask;
   logic [FW-1:0]        frame_num;
   logic [NUM_CH-1:0]    fifo_empty;
   logic [NUM_CH-1:0]    fifo_rden;
   logic [NUM_CH*DW-1:0] fifo_rxd;
   logic                 ram_txen;
   logic [AW-1:0]        ram_txa;
   logic [DW-1:0]        ram_txd;
   logic [AW-1:0]        data_len;
   logic                 err_timeout;

   modport master (
      output fs, ram_txa_init, ch_mask, frame_num,
      output fifo_empty, fifo_rxd,
      input  fd, fifo_rden, ram_txen, ram_txa, ram_txd,
      input  data_len, err_timeout
   );

   modport slave (
      input  fs, ram_txa_init, ch_mask, frame_num,
      input  fifo_empty, fifo_rxd,
      output fd, fifo_rden, ram_txen, ram_txa, ram_txd,
      output data_len, err_timeout
   );
endinterface

// File: rtl/adc2ram_mc.sv
// adc2ram_mc: round-robin drain of NUM_CH ADC FIFOs into
// frame RAM port A, with channel mask, frame count and stall fill.
module adc2ram_mc #(
   parameter int            NUM_CH  = 8,
   parameter int            DW      = 8,
   parameter int            AW      = 12,
   parameter int            FW      = 8,
   parameter int            TIMEOUT = 1024,
   parameter logic [DW-1:0] FILL    = 8'h00
) (
   input logic         clk,
   input logic         rst_n,
   adc2ram_mc_if.slave bus
);

   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_SEL   = 3'd2;
   localparam logic [2:0] S_READ  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_FILLW = 3'd5;
   localparam logic [2:0] S_NEXT  = 3'd6;
   localparam logic [2:0] S_DONE  = 3'd7;

   logic [2:0]        state_q, state_d;
   logic [AW-1:0]     base_q, base_d;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic [FW-1:0]     frames_q, frames_d;
   logic [FW-1:0]     frame_q, frame_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [AW-1:0]     off_q, off_d;
   logic [AW-1:0]     len_q, len_d;
   logic              err_q, err_d;
   logic              fd_q, fd_d;
   logic [NUM_CH-1:0] rden_q, rden_d;
   logic              txen_q, txen_d;
   logic [AW-1:0]     txa_q, txa_d;
   logic [DW-1:0]     txd_q, txd_d;

   logic [IW-1:0]     ld_idx;
   logic [IW-1:0]     lo_idx;
   logic [IW-1:0]     nx_idx;
   logic              nx_found;
   logic [DW-1:0]     rxd_sel;

   // Priority searches: lowest enabled channel of the incoming
   // mask, of the latched mask, and the next one above idx.
   always_comb begin
      ld_idx   = '0;
      lo_idx   = '0;
      nx_idx   = '0;
      nx_found = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (bus.ch_mask[i]) ld_idx = IW'(i);
         if (mask_q[i]) lo_idx = IW'(i);
         if (mask_q[i] && (i > int'(idx_q))) begin
            nx_idx   = IW'(i);
            nx_found = 1'b1;
         end
      end
   end

   // Data of the channel being written, returned by its FIFO.
   always_comb begin
      rxd_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (idx_q == IW'(i)) rxd_sel = bus.fifo_rxd[i*DW +: DW];
      end
   end

   // Run sequencer: next state and next values of all outputs.
   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      mask_d   = mask_q;
      frames_d = frames_q;
      frame_d  = frame_q;
      idx_d    = idx_q;
      tmo_d    = tmo_q;
      off_d    = off_q;
      len_d    = len_q;
      err_d    = err_q;
      fd_d     = fd_q;
      rden_d   = '0;
      txen_d   = 1'b0;
      txa_d    = txa_q;
      txd_d    = txd_q;
      case (state_q)
         S_IDLE: begin
            fd_d = 1'b0;
            if (bus.fs) state_d = S_LOAD;
         end
         S_LOAD: begin
            base_d   = bus.ram_txa_init;
            mask_d   = bus.ch_mask;
            frames_d = bus.frame_num;
            frame_d  = '0;
            idx_d    = ld_idx;
            tmo_d    = '0;
            off_d    = '0;
            len_d    = '0;
            err_d    = 1'b0;
            if (bus.ch_mask == '0 || bus.frame_num == '0) begin
               state_d = bus.fs ? S_DONE : S_IDLE;
               fd_d    = bus.fs;
            end else begin
               state_d = S_SEL;
            end
         end
         S_SEL: begin
            if (!mask_q[idx_q]) begin
               state_d = S_NEXT;
            end else if (!bus.fifo_empty[idx_q]) begin
               rden_d[idx_q] = 1'b1;
               state_d       = S_READ;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               state_d = S_FILLW;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_READ: begin
            state_d = S_WRITE;
         end
         S_WRITE, S_FILLW: begin
            txen_d = 1'b1;
            txa_d  = base_q + off_q;
            txd_d  = (state_q == S_FILLW) ? FILL : rxd_sel;
            if (state_q == S_FILLW) err_d = 1'b1;
            off_d  = off_q + AW'(1);
            if (len_q != '1) len_d = len_q + AW'(1);
            tmo_d   = '0;
            state_d = S_NEXT;
         end
         S_NEXT: begin
            if (nx_found) begin
               idx_d   = nx_idx;
               state_d = S_SEL;
            end else if (frame_q + FW'(1) == frames_q) begin
               state_d = bus.fs ? S_DONE : S_IDLE;
               fd_d    = bus.fs;
            end else begin
               frame_d = frame_q + FW'(1);
               idx_d   = lo_idx;
               state_d = S_SEL;
            end
         end
         S_DONE: begin
            fd_d = bus.fs;
            if (!bus.fs) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         base_q   <= '0;
         mask_q   <= '0;
         frames_q <= '0;
         frame_q  <= '0;
         idx_q    <= '0;
         tmo_q    <= '0;
         off_q    <= '0;
         len_q    <= '0;
         err_q    <= 1'b0;
         fd_q     <= 1'b0;
         rden_q   <= '0;
         txen_q   <= 1'b0;
         txa_q    <= '0;
         txd_q    <= '0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         mask_q   <= mask_d;
         frames_q <= frames_d;
         frame_q  <= frame_d;
         idx_q    <= idx_d;
         tmo_q    <= tmo_d;
         off_q    <= off_d;
         len_q    <= len_d;
         err_q    <= err_d;
         fd_q     <= fd_d;
         rden_q   <= rden_d;
         txen_q   <= txen_d;
         txa_q    <= txa_d;
         txd_q    <= txd_d;
      end
   end

   assign bus.fd          = fd_q;
   assign bus.fifo_rden   = rden_q;
   assign bus.ram_txen    = txen_q;
   assign bus.ram_txa     = txa_q;
   assign bus.ram_txd     = txd_q;
   assign bus.data_len    = len_q;
   assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_adc2ram_mc.sv
// tb_adc2ram_mc: directed runs with a write scoreboard checked
// by a monitor process at the falling clock edge.
module tb_adc2ram_mc;
   localparam int NUM_CH  = 8;
   localparam int DW      = 8;
   localparam int AW      = 12;
   localparam int FW      = 8;
   localparam int TIMEOUT = 16;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   adc2ram_mc_if #(.NUM_CH(NUM_CH), .DW(DW), .AW(AW), .FW(FW)) bus ();

   adc2ram_mc #(
      .NUM_CH(NUM_CH), .DW(DW), .AW(AW), .FW(FW),
      .TIMEOUT(TIMEOUT), .FILL(8'h00)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   wr_t               exp_q[$];
   int                wr_cyc[$];
   int                total = 0;
   int                bad = 0;
   int                cyc = 0;
   int                wr_cnt = 0;
   int                rden_cnt = 0;
   logic [NUM_CH-1:0] hold_empty = '0;
   logic [NUM_CH-1:0] run_mask = '0;
   int                rd_cnt[NUM_CH];
   int                base_cnt[NUM_CH];
   logic [DW-1:0]     rxd[NUM_CH];

   // FIFO model: channel i returns {i, k} for its k-th read of a run.
   always @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (bus.fifo_rden[i]) begin
            rxd[i]    <= {i[3:0], 4'(rd_cnt[i] - base_cnt[i])};
            rd_cnt[i] <= rd_cnt[i] + 1;
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_rxd
      assign bus.fifo_rxd[g*DW +: DW] = rxd[g];
   end
   assign bus.fifo_empty = hold_empty;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic monitor();
      wr_t e;
      if (bus.fifo_rden != '0) begin
         rden_cnt++;
         chk("rden_onehot", 32'($onehot(bus.fifo_rden)), 1);
         chk("rden_legal", 32'(bus.fifo_rden & ~(run_mask & ~hold_empty)), 0);
      end
      if (bus.ram_txen) begin
         wr_cnt++;
         wr_cyc.push_back(cyc);
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write addr=%h data=%h",
                     bus.ram_txa, bus.ram_txd);
         end else begin
            e = exp_q.pop_front();
            if (bus.ram_txa !== e.a || bus.ram_txd !== e.d) begin
               bad++;
               $display("FAIL write actual=%h:%h required=%h:%h",
                        bus.ram_txa, bus.ram_txd, e.a, e.d);
            end
         end
      end
   endtask

   task automatic prep(input logic [AW-1:0] init,
                       input logic [NUM_CH-1:0] m,
                       input logic [FW-1:0] fr,
                       input logic [NUM_CH-1:0] he,
                       output int n_rd, output logic fill);
      int off;
      wr_t e;
      off  = 0;
      n_rd = 0;
      fill = 1'b0;
      hold_empty = he;
      run_mask   = m;
      for (int i = 0; i < NUM_CH; i++) base_cnt[i] = rd_cnt[i];
      exp_q.delete();
      wr_cyc.delete();
      for (int f = 0; f < int'(fr); f++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (m[c]) begin
               e.a = init + AW'(off);
               e.d = he[c] ? 8'h00 : {c[3:0], f[3:0]};
               exp_q.push_back(e);
               off++;
               if (he[c]) fill = 1'b1;
               else n_rd++;
            end
         end
      end
      wr_cnt   = 0;
      rden_cnt = 0;
   endtask

   task automatic run_job(input logic [AW-1:0] init,
                          input logic [NUM_CH-1:0] m,
                          input logic [FW-1:0] fr,
                          input logic [NUM_CH-1:0] he,
                          input int exp_len, input int fd_lim);
      int   n_rd;
      logic fill;
      int   n;
      prep(init, m, fr, he, n_rd, fill);
      bus.ram_txa_init = init;
      bus.ch_mask      = m;
      bus.frame_num    = fr;
      bus.fs           = 1'b1;
      n = 0;
      while (!bus.fd && n < 3000) begin
         @(negedge clk);
         n++;
         if (n == 2) begin
            bus.ch_mask      = ~m;
            bus.frame_num    = fr + 8'd3;
            bus.ram_txa_init = init + 12'h040;
         end
      end
      chk("fd_rise", 32'(bus.fd), 1);
      if (fd_lim > 0) chk("fd_latency", 32'(n <= fd_lim), 1);
      chk("writes_left", exp_q.size(), 0);
      chk("wr_count", wr_cnt, exp_len);
      chk("data_len", 32'(bus.data_len), exp_len);
      chk("err_timeout", 32'(bus.err_timeout), 32'(fill));
      chk("rden_count", rden_cnt, n_rd);
      bus.fs = 1'b0;
      @(negedge clk);
      chk("fd_fall", 32'(bus.fd), 0);
      @(negedge clk);
      chk("len_hold", 32'(bus.data_len), exp_len);
      exp_q.delete();
   endtask

   task automatic stimulus();
      int   n_rd;
      logic fill;
      int   n;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_fd", 32'(bus.fd), 0);
      chk("rst_txen", 32'(bus.ram_txen), 0);
      chk("rst_rden", 32'(bus.fifo_rden), 0);
      chk("rst_txa", 32'(bus.ram_txa), 0);
      chk("rst_len", 32'(bus.data_len), 0);
      chk("rst_err", 32'(bus.err_timeout), 0);

      run_job(12'h100, 8'hFF, 8'd2, 8'h00, 16, 0);
      run_job(12'h300, 8'h05, 8'd3, 8'h00, 6, 0);
      run_job(12'hFFE, 8'h03, 8'd2, 8'h00, 4, 0);
      run_job(12'h200, 8'h0F, 8'd1, 8'h08, 4, 0);
      chk("fill_writes", wr_cyc.size(), 4);
      if (wr_cyc.size() >= 4) begin
         n = wr_cyc[3] - wr_cyc[2];
         chk("fill_gap", 32'(n >= TIMEOUT && n <= TIMEOUT + 4), 1);
      end
      run_job(12'h123, 8'h00, 8'd4, 8'h00, 0, 3);
      run_job(12'h123, 8'hFF, 8'd0, 8'h00, 0, 3);

      prep(12'h100, 8'hFF, 8'd2, 8'h00, n_rd, fill);
      bus.ram_txa_init = 12'h100;
      bus.ch_mask      = 8'hFF;
      bus.frame_num    = 8'd2;
      bus.fs           = 1'b1;
      n = 0;
      while (wr_cnt < 5 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("rst_at_wr5", wr_cnt, 5);
      rst_n  = 1'b0;
      bus.fs = 1'b0;
      @(negedge clk);
      chk("mid_rst_ctl", 32'({bus.fd, bus.ram_txen, bus.err_timeout, bus.fifo_rden}), 0);
      chk("mid_rst_txa", 32'(bus.ram_txa), 0);
      chk("mid_rst_txd", 32'(bus.ram_txd), 0);
      chk("mid_rst_len", 32'(bus.data_len), 0);
      repeat (2) @(negedge clk);
      chk("mid_rst_quiet", wr_cnt, 5);
      exp_q.delete();
      rst_n = 1'b1;
      @(negedge clk);
      run_job(12'h100, 8'hFF, 8'd2, 8'h00, 16, 0);
   endtask

   initial begin
      bus.fs           = 1'b0;
      bus.ram_txa_init = '0;
      bus.ch_mask      = '0;
      bus.frame_num    = '0;
      fork
         forever begin
            @(negedge clk);
            cyc++;
            monitor();
         end
         begin
            stimulus();
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
      join
   end
endmodule
